memory: RTL and testbench
=========================

Name: memory

Overview:
- Unified data memory for the RISC-V core: synchronous-read / synchronous-write RAM with a memory-mapped output port.
- Supports byte, halfword and word loads/stores, selected by the load/store funct3.
- A flash (preload) interface, active only while reset is asserted, initialises RAM contents before the core runs.

Parameters:
- WIDTH, 32, data/address width in bits.
- DEPTH, 1024, RAM size in WIDTH-bit words.
  - Byte address range is 0 .. 4*DEPTH-1.
  - OUTPORT_ADDR (constant from the common package) must lie outside this range.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  WIDTH  byte address for core read/write.
- wren  in  1  0 = read, 1 = write.
- wr_data  in  WIDTH  store data, right-aligned for byte/half.
- funct3  in  funct3_t  access size/sign (LOAD_STORE_FNS encoding): BYTE/LB=000, HALF/LH=001, WORD/LW=010, LBU=100, LHU=101.
- flash_addr  in  WIDTH  byte address for preload.
- flash_data  in  WIDTH  word to preload.
- flash_en  in  1  preload write strobe.
- rd_data  out  WIDTH  registered load data.
- outport  out  WIDTH  registered output-port value.

Behaviour:
- Reset (rst=1, asynchronous):
  - rd_data=0, outport=0.
  - RAM contents are NOT cleared.
  - Core writes (wren) are ignored.
- Flash:
  - While rst=1, on each rising clk with flash_en=1, store the full word flash_data at RAM word flash_addr[log2(DEPTH)+1:2].
  - flash_en is ignored when rst=0.
  - flash_addr[1:0] is ignored.
- Address decode (rst=0):
  - word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
  - addr in 0 .. 4*DEPTH-1 selects RAM.
  - addr == OUTPORT_ADDR selects the output port.
  - Any other address is unmapped.
- Store (wren=1, rising clk):
  - RAM, WORD: all 4 bytes written; lane ignored.
  - RAM, HALF: wr_data[15:0] written to bytes {lane[1],0} and {lane[1],1}; lane[0] ignored.
  - RAM, BYTE: wr_data[7:0] written to byte lane.
  - OUTPORT_ADDR: outport <= wr_data (full word regardless of funct3); RAM unchanged.
  - Unmapped: no effect.
- Load:
  - rd_data is registered on every rising clk (rst=0) from the current addr and funct3.
  - Latency: 1 clock. A value applied before edge N is visible after edge N.
  - RAM, LW: the full word.
  - RAM, LH: halfword at lane[1], sign-extended. LHU: same, zero-extended.
  - RAM, LB: byte at lane, sign-extended. LBU: same, zero-extended.
  - Other funct3 codes: treated as LW.
  - OUTPORT_ADDR or unmapped: rd_data = 0.
- Read-during-write (same edge, wren=1, RAM address): write-first.
  - rd_data shows the merged post-write word, formatted per funct3.
  - After a 1-cycle wren pulse, rd_data equals the newly written data immediately after that edge.
- outport holds its value until the next write to OUTPORT_ADDR or reset.
- Reset asserted mid-operation clears rd_data and outport immediately. A write on the same edge as reset assertion is dropped.

Test Plan:
- Preload under rst=1: flash 12345@0, 678910@4, 0xFFFFFFFF@12; release rst; read addr 0, 4, 12 with WORD, waiting 2 clocks each -> rd_data 12345, 678910, 0xFFFFFFFF. Also check flash_en pulsed with rst=0 has no effect.
- Write-first: addr=8, wr_data=101010, 1-cycle wren pulse -> rd_data=101010 right after the edge; re-read later -> 101010.
- Outport: addr=OUTPORT_ADDR, wr_data=0xDEADBEEF, wren pulse -> outport=0xDEADBEEF; rd_data != 0xDEADBEEF (reads 0); RAM words 0/4/8/12 unchanged.
- Sub-word:
  - SB 0x80 to addr 5 -> word@4 byte1=0x80, other bytes unchanged.
  - LB@5 -> 0xFFFFFF80; LBU@5 -> 0x00000080.
  - SH 0x8001 to addr 2, then LH@2 -> 0xFFFF8001; LHU@2 -> 0x00008001.
- Reset mid-run: after outport=0xDEADBEEF, assert rst asynchronously between edges -> outport=0, rd_data=0 immediately; RAM word@0 still 12345 after release.
- Unmapped read: addr beyond 4*DEPTH (not OUTPORT_ADDR) -> rd_data=0; write there -> no RAM/outport change.

Source files
------------

// File: rtl/memory.sv
// Unified data memory for the RISC-V core: byte/half/word load-store RAM,
// a memory-mapped output port, and a preload (flash) path that is only
// active while reset is held.
//
// Core access protocol: there is no valid/ready handshake. Every rising
// clock with rst=0 is an access cycle. wren=1 stores wr_data at addr and
// wren=0 is a load. rd_data always shows the load result for the addr and
// funct3 presented before the previous edge. A store also produces a
// load result, which is the post-write (write-first) view of the word.

package memory_pkg;
  // Load/store funct3 encoding (LOAD_STORE_FNS).
  typedef logic [2:0] funct3_t;
  localparam funct3_t F3_BYTE  = 3'b000;  // SB / LB
  localparam funct3_t F3_HALF  = 3'b001;  // SH / LH
  localparam funct3_t F3_WORD  = 3'b010;  // SW / LW
  localparam funct3_t F3_BYTEU = 3'b100;  // LBU
  localparam funct3_t F3_HALFU = 3'b101;  // LHU

  // Memory-mapped output port. It sits well above any RAM range.
  localparam logic [31:0] OUTPORT_ADDR = 32'hFFFF_0000;
endpackage

module memory
  import memory_pkg::*;
#(
  parameter int WIDTH = 32,   // lane logic below assumes four byte lanes
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             wren,
  input  logic [WIDTH-1:0] wr_data,
  input  funct3_t          funct3,
  input  logic [WIDTH-1:0] flash_addr,
  input  logic [WIDTH-1:0] flash_data,
  input  logic             flash_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] outport
);

  localparam int AW = $clog2(DEPTH);
  // One bit wider than addr so the byte count itself is representable.
  localparam logic [WIDTH:0] RAM_BYTES = (WIDTH+1)'(4 * DEPTH);

  // Storage and output registers.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] outport_q, outport_d;

  // Decode.
  logic             ram_sel;
  logic             out_sel;
  logic [AW-1:0]    word_idx;
  logic [AW-1:0]    flash_idx;
  logic [1:0]       lane;

  // Write path.
  logic [3:0]       byte_en;
  logic [WIDTH-1:0] wr_lanes;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] merged_word;
  logic             ram_we;
  logic             flash_we;
  logic             out_we;

  // Load formatting.
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [WIDTH-1:0] load_val;

  // The word-index slice covers only the low address bits. These bits
  // are unused: the upper flash address bits, because flash only targets
  // the RAM, and the flash lane bits, because preload is whole-word.
  logic             unused_flash_bits;
  assign unused_flash_bits = ^{flash_addr[WIDTH-1:AW+2], flash_addr[1:0]};

  // Address decode: RAM range, output port, or unmapped (neither).
  always_comb begin
    ram_sel   = ({1'b0, addr} < RAM_BYTES);
    out_sel   = (addr == WIDTH'(OUTPORT_ADDR));
    word_idx  = addr[AW+1:2];
    flash_idx = flash_addr[AW+1:2];
    lane      = addr[1:0];
  end

  // Write strobes. Core writes are blocked while reset is held, and flash
  // writes are only allowed while reset is held.
  always_comb begin
    ram_we   = !rst && wren && ram_sel;
    out_we   = wren && out_sel;
    flash_we = rst && flash_en;
  end

  // Byte enables and lane-replicated store data from the store size.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = wr_data;
    case (funct3[1:0])
      2'b00: begin
        byte_en[lane] = 1'b1;
        wr_lanes      = {4{wr_data[7:0]}};
      end
      2'b01: begin
        byte_en[{lane[1], 1'b0}] = 1'b1;
        byte_en[{lane[1], 1'b1}] = 1'b1;
        wr_lanes                 = {2{wr_data[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = wr_data;
      end
    endcase
  end

  // Merge store lanes into the addressed word. The merged word feeds both
  // the RAM write and the load path, so a load in the same cycle as a
  // store sees the new data (write-first).
  always_comb begin
    cur_word    = mem_q[word_idx];
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (ram_we && byte_en[i]) begin
        merged_word[i*8 +: 8] = wr_lanes[i*8 +: 8];
      end
    end
  end

  // Load formatting: pick the byte or halfword and extend it. Any other
  // funct3 code reads as a full word. Non-RAM addresses read as zero.
  always_comb begin
    sel_byte = merged_word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? merged_word[31:16] : merged_word[15:0];
    case (funct3)
      F3_BYTE:  load_val = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
      F3_BYTEU: load_val = {{(WIDTH-8){1'b0}}, sel_byte};
      F3_HALF:  load_val = {{(WIDTH-16){sel_half[15]}}, sel_half};
      F3_HALFU: load_val = {{(WIDTH-16){1'b0}}, sel_half};
      default:  load_val = merged_word;
    endcase
    rd_data_d = ram_sel ? load_val : '0;
  end

  // The output port takes the full store word regardless of funct3.
  always_comb begin
    outport_d = outport_q;
    if (out_we) begin
      outport_d = wr_data;
    end
  end

  // RAM array: preload during reset, core stores afterwards. The array is
  // never cleared, so preloaded contents survive the reset release.
  always_ff @(posedge clk) begin
    if (flash_we) begin
      mem_q[flash_idx] <= flash_data;
    end else if (ram_we) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  // Registered load data and output port, both cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      outport_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      outport_q <= outport_d;
    end
  end

  assign rd_data = rd_data_q;
  assign outport = outport_q;

endmodule

// File: tb/tb_memory.sv
// Bench for the data memory: reset state, preload, a table of directed
// accesses with hand-derived results, reset mid-run, and random traffic
// checked against a byte-addressed reference model.

module tb_memory;
  import memory_pkg::*;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4 * DEPTH;

  // Clock and reset.
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wren;
  logic [31:0] wr_data;
  funct3_t     funct3;
  logic [31:0] flash_addr;
  logic [31:0] flash_data;
  logic        flash_en;
  logic [31:0] rd_data;
  logic [31:0] outport;

  always #5 clk = ~clk;

  memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wren       (wren),
    .wr_data    (wr_data),
    .funct3     (funct3),
    .flash_addr (flash_addr),
    .flash_data (flash_data),
    .flash_en   (flash_en),
    .rd_data    (rd_data),
    .outport    (outport)
  );

  // Scoreboard state.
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_out_q [$];

  // Reference model: a plain byte array plus the output-port value.
  logic [7:0]  m_mem [NBYTES];
  logic [31:0] m_out;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
    int          b;
    int          hb;
    logic [31:0] w;
    logic [7:0]  by;
    logic [15:0] h;
    if (a >= 32'(NBYTES)) return 32'd0;
    b  = int'(a) & ~3;
    hb = b + (int'(a) & 2);
    w  = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
    by = m_mem[int'(a)];
    h  = {m_mem[hb+1], m_mem[hb]};
    case (f3)
      3'd0:    return {{24{by[7]}}, by};
      3'd4:    return {24'd0, by};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int b;
    int hb;
    if (a < 32'(NBYTES)) begin
      b  = int'(a) & ~3;
      hb = b + (int'(a) & 2);
      case (f3)
        3'd0: m_mem[int'(a)] = d[7:0];
        3'd1: begin
          m_mem[hb]   = d[7:0];
          m_mem[hb+1] = d[15:8];
        end
        default: begin
          m_mem[b]   = d[7:0];
          m_mem[b+1] = d[15:8];
          m_mem[b+2] = d[23:16];
          m_mem[b+3] = d[31:24];
        end
      endcase
    end else if (a == OUTPORT_ADDR) begin
      m_out = d;
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flash_word(input logic [31:0] a, input logic [31:0] d);
    int b;
    flash_addr = a;
    flash_data = d;
    flash_en   = 1'b1;
    step();
    flash_en   = 1'b0;
    b = int'(a[11:0]) & ~3;
    m_mem[b]   = d[7:0];
    m_mem[b+1] = d[15:8];
    m_mem[b+2] = d[23:16];
    m_mem[b+3] = d[31:24];
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic we, input logic [31:0] d,
                              input logic [2:0] f3, input logic [31:0] er, input logic [31:0] eo);
    vec_t v;
    v.addr = a; v.we = we; v.data = d; v.f3 = f3; v.exp_rd = er; v.exp_out = eo;
    return v;
  endfunction

  initial begin
    logic [31:0] ra;
    logic        rwe;
    logic [31:0] rd;
    logic [2:0]  rf3;
    logic [31:0] e_rd;
    logic [31:0] e_out;
    int          sel;

    rst        = 1'b1;
    addr       = '0;
    wren       = 1'b0;
    wr_data    = '0;
    funct3     = F3_WORD;
    flash_addr = '0;
    flash_data = '0;
    flash_en   = 1'b0;
    m_out      = '0;

    // Reset state.
    step();
    step();
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_outport", outport, 32'd0);

    // Preload every word (random lane bits, which must be ignored), then
    // the known test words.
    for (int w = 0; w < DEPTH; w++) begin
      flash_word(32'(w * 4 + int'($urandom_range(0, 3))), $urandom);
    end
    flash_word(32'd0,  32'd12345);
    flash_word(32'd5,  32'd678910);
    flash_word(32'd12, 32'hFFFF_FFFF);

    // Core writes during reset are ignored.
    addr    = OUTPORT_ADDR;
    wr_data = 32'h0000_0077;
    wren    = 1'b1;
    step();
    addr    = 32'd0;
    wr_data = 32'h5A5A_5A5A;
    step();
    wren    = 1'b0;
    check("reset_wr_outport", outport, 32'd0);

    // Release reset, then pulse flash_en, which must now be ignored.
    rst        = 1'b0;
    flash_addr = 32'd0;
    flash_data = 32'hBAD0_BAD0;
    flash_en   = 1'b1;
    step();
    flash_en   = 1'b0;

    // Directed table.
    tbl.push_back(mk(32'd0,        1'b0, 32'd0,          3'd2, 32'd12345,      32'd0));
    tbl.push_back(mk(32'd4,        1'b0, 32'd0,          3'd2, 32'd678910,     32'd0));
    tbl.push_back(mk(32'd12,       1'b0, 32'd0,          3'd2, 32'hFFFF_FFFF,  32'd0));
    tbl.push_back(mk(32'd8,        1'b1, 32'd101010,     3'd2, 32'd101010,     32'd0));
    tbl.push_back(mk(32'd8,        1'b0, 32'd0,          3'd2, 32'd101010,     32'd0));
    tbl.push_back(mk(OUTPORT_ADDR, 1'b1, 32'hDEAD_BEEF,  3'd2, 32'd0,          32'hDEAD_BEEF));
    tbl.push_back(mk(OUTPORT_ADDR, 1'b0, 32'd0,          3'd2, 32'd0,          32'hDEAD_BEEF));
    tbl.push_back(mk(32'd0,        1'b0, 32'd0,          3'd2, 32'd12345,      32'hDEAD_BEEF));
    tbl.push_back(mk(32'd4,        1'b0, 32'd0,          3'd2, 32'd678910,     32'hDEAD_BEEF));
    tbl.push_back(mk(32'd8,        1'b0, 32'd0,          3'd2, 32'd101010,     32'hDEAD_BEEF));
    tbl.push_back(mk(32'd12,       1'b0, 32'd0,          3'd2, 32'hFFFF_FFFF,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd5,        1'b1, 32'hAAAA_AA80,  3'd0, 32'hFFFF_FF80,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd4,        1'b0, 32'd0,          3'd2, 32'h000A_80FE,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd5,        1'b0, 32'd0,          3'd0, 32'hFFFF_FF80,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd5,        1'b0, 32'd0,          3'd4, 32'h0000_0080,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd2,        1'b1, 32'h1234_8001,  3'd1, 32'hFFFF_8001,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd2,        1'b0, 32'd0,          3'd1, 32'hFFFF_8001,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd2,        1'b0, 32'd0,          3'd5, 32'h0000_8001,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd0,        1'b0, 32'd0,          3'd2, 32'h8001_3039,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd3,        1'b0, 32'd0,          3'd0, 32'hFFFF_FF80,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd1,        1'b0, 32'd0,          3'd4, 32'h0000_0030,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd7,        1'b1, 32'h0000_ABCD,  3'd1, 32'hFFFF_ABCD,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd4,        1'b0, 32'd0,          3'd2, 32'hABCD_80FE,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd6,        1'b0, 32'd0,          3'd5, 32'h0000_ABCD,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd14,       1'b1, 32'h1122_3344,  3'd2, 32'h1122_3344,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd12,       1'b0, 32'd0,          3'd3, 32'h1122_3344,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd13,       1'b0, 32'd0,          3'd0, 32'h0000_0033,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd15,       1'b0, 32'd0,          3'd0, 32'h0000_0011,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd4096,     1'b1, 32'h1234_5678,  3'd2, 32'd0,          32'hDEAD_BEEF));
    tbl.push_back(mk(32'd0,        1'b0, 32'd0,          3'd2, 32'h8001_3039,  32'hDEAD_BEEF));
    tbl.push_back(mk(32'd4096,     1'b0, 32'd0,          3'd2, 32'd0,          32'hDEAD_BEEF));
    tbl.push_back(mk(32'h0010_0000, 1'b0, 32'd0,         3'd2, 32'd0,          32'hDEAD_BEEF));

    foreach (tbl[i]) begin
      addr    = tbl[i].addr;
      wren    = tbl[i].we;
      wr_data = tbl[i].data;
      funct3  = tbl[i].f3;
      if (tbl[i].we) m_store(tbl[i].addr, tbl[i].data, tbl[i].f3);
      step();
      wren = 1'b0;
      check($sformatf("tbl%0d_rd", i), rd_data, tbl[i].exp_rd);
      check($sformatf("tbl%0d_out", i), outport, tbl[i].exp_out);
    end

    // Reset asserted between edges, with a write pending on the next edge.
    addr    = 32'd0;
    wr_data = 32'h5555_5555;
    funct3  = F3_WORD;
    wren    = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_outport", outport, 32'd0);
    check("midrst_rd_data", rd_data, 32'd0);
    step();
    wren  = 1'b0;
    rst   = 1'b0;
    m_out = 32'd0;
    step();
    check("midrst_word0", rd_data, 32'h8001_3039);
    check("midrst_out_held", outport, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       ra = 32'($urandom_range(0, NBYTES - 1));
      else if (sel == 8) ra = OUTPORT_ADDR;
      else               ra = 32'(NBYTES) + 32'($urandom_range(0, 32'h000F_FFFF));
      rwe = 1'($urandom_range(0, 1));
      rd  = $urandom;
      rf3 = rwe ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      if (rwe) m_store(ra, rd, rf3);
      exp_q.push_back(m_load(ra, rf3));
      exp_out_q.push_back(m_out);
      addr    = ra;
      wren    = rwe;
      wr_data = rd;
      funct3  = rf3;
      step();
      wren  = 1'b0;
      e_rd  = exp_q.pop_front();
      e_out = exp_out_q.pop_front();
      check($sformatf("rand%0d_rd a=%08h f3=%0d we=%0b", i, ra, rf3, rwe), rd_data, e_rd);
      check($sformatf("rand%0d_out", i), outport, e_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
